// File: rtl/wb_uart_pkg.sv
// rtl/wb_uart_pkg.sv - shared types and register map for the Wishbone UART transmitter
package wb_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  function automatic logic [15:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [15:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - classic single-cycle Wishbone bus, 16-bit address and data
interface if_wb;
  logic [15:0] adr;
  logic [15:0] dat_o;
  logic [15:0] dat_i;
  logic        stb;
  logic        cyc;
  logic        we;
  logic        ack;

  // dat_o is initiator write data, dat_i is responder read data
  modport slave  (input adr, dat_o, stb, cyc, we, output dat_i, ack);
  modport master (output adr, dat_o, stb, cyc, we, input dat_i, ack);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still safe
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - zero-wait-state Wishbone responder feeding an 8N1 serial transmitter
module wb_uart_tx #(
  parameter logic [15:0] BASE_ADR     = 16'h7000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic clk,
  input  logic reset,
  if_wb.slave  wb,
  output logic tx,
  output logic irq
);
  import wb_uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            sel;
  logic            wr;
  logic            rd;
  logic            wr_txdata;
  logic            wr_bauddiv;
  logic            rd_status;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [7:0]      fifo_rdata;
  logic            overflow;
  logic [15:0]     bauddiv;
  logic [15:0]     div_act;
  logic [15:0]     cnt;
  logic            tick;
  tx_state_t       state;
  logic [7:0]      shreg;
  logic [2:0]      idx;
  logic [15:0]     rd_data;

  assign sel        = wb.cyc & wb.stb & (wb.adr[15:2] == BASE_ADR[15:2]);
  assign wr         = sel & wb.we;
  assign rd         = sel & ~wb.we;
  assign wb.ack     = sel;
  assign wb.dat_i   = rd_data;
  assign wr_txdata  = wr & (wb.adr[1:0] == REG_TXDATA);
  assign wr_bauddiv = wr & (wb.adr[1:0] == REG_BAUDDIV);
  assign rd_status  = rd & (wb.adr[1:0] == REG_STATUS);
  assign push       = wr_txdata & ~full;
  assign pop        = (state == IDLE) & ~empty;
  assign tick       = (state != IDLE) & (cnt == div_act);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wb.dat_o[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (wb.adr[1:0])
        REG_STATUS:  rd_data = pack_status(full, empty, state != IDLE, overflow,
                                           STAT_CNT_W'(count));
        REG_BAUDDIV: rd_data = bauddiv;
        default:     rd_data = '0;
      endcase
    end
  end

  // overflow set takes priority over the read-to-clear of STATUS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      bauddiv  <= BAUD_DIV_RST;
    end else begin
      if (wr_txdata & full)  overflow <= 1'b1;
      else if (rd_status)    overflow <= 1'b0;
      if (wr_bauddiv)        bauddiv  <= wb.dat_o;
    end
  end

  // div_act is the compare value latched at each counter reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      cnt     <= '0;
      div_act <= BAUD_DIV_RST;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      irq <= empty & (state == IDLE);
      if (state != IDLE) begin
        if (tick) begin
          cnt     <= '0;
          div_act <= bauddiv;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shreg   <= fifo_rdata;
            cnt     <= '0;
            div_act <= bauddiv;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            idx   <= 3'd0;
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shreg[idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb/tb_wb_uart_tx.sv - directed bench for wb_uart_tx with a serial-frame scoreboard
module tb_wb_uart_tx;

  localparam logic [15:0] BASE = 16'h7000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic irq;

  if_wb wb();

  wb_uart_tx #(.BASE_ADR(BASE), .FIFO_DEPTH(8), .BAUD_DIV_RST(16'd433)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bit_clks = 434;
  logic [7:0] exp_q[$];
  int start_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // serial decoder: samples each bit mid-period and checks against the scoreboard
  initial begin
    logic mon_busy;
    logic mon_prev;
    int mon_wait;
    int mon_bit;
    logic [7:0] mon_byte;
    logic [7:0] e;
    mon_busy = 1'b0;
    mon_prev = 1'b1;
    mon_wait = 0;
    mon_bit = 0;
    mon_byte = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_busy = 1'b0;
        mon_prev = 1'b1;
      end else begin
        if (!mon_busy) begin
          if (mon_prev && !tx) begin
            mon_busy = 1'b1;
            mon_bit = 0;
            mon_wait = bit_clks / 2;
            start_q.push_back(cyc);
          end
        end else begin
          mon_wait--;
          if (mon_wait <= 0) begin
            if (mon_bit == 0) begin
              chk("start_bit", 32'(tx), 32'd0);
            end else if (mon_bit <= 8) begin
              mon_byte[mon_bit-1] = tx;
            end else begin
              chk("stop_bit", 32'(tx), 32'd1);
              chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("frame_byte", 32'(mon_byte), 32'(e));
              end
              mon_busy = 1'b0;
            end
            mon_bit++;
            mon_wait = bit_clks;
          end
        end
        mon_prev = tx;
      end
    end
  end

  task automatic bus(input logic [15:0] adr, input logic we, input logic [15:0] wdat,
                     input logic cyc_i, output logic ack_o, output logic [15:0] rdat);
    @(negedge clk);
    wb.adr = adr;
    wb.we = we;
    wb.dat_o = wdat;
    wb.cyc = cyc_i;
    wb.stb = 1'b1;
    #1;
    ack_o = wb.ack;
    rdat = wb.dat_i;
    @(posedge clk);
    #1;
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [15:0] adr, input logic [15:0] d);
    logic a;
    logic [15:0] r;
    bus(adr, 1'b1, d, 1'b1, a, r);
    chk(tag, 32'(a), 32'd1);
  endtask

  task automatic rd_reg(input string tag, input logic [15:0] adr, input logic [15:0] exp);
    logic a;
    logic [15:0] r;
    bus(adr, 1'b0, 16'h0000, 1'b1, a, r);
    chk({tag, "_ack"}, 32'(a), 32'd1);
    chk(tag, 32'(r), 32'(exp));
  endtask

  task automatic push_byte(input logic [7:0] d, input logic accept);
    if (accept) exp_q.push_back(d);
    wr_reg("txdata_ack", BASE, {8'h00, d});
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(irq), 32'd1);
  endtask

  initial begin
    logic a;
    logic [15:0] r;
    logic [9:0] frame;
    int low_seen;

    wb.adr = '0;
    wb.dat_o = '0;
    wb.stb = 1'b0;
    wb.cyc = 1'b0;
    wb.we = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd1);
    chk("rst_ack", 32'(wb.ack), 32'd0);
    chk("rst_dat_i", 32'(wb.dat_i), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd_reg("rst_status", BASE + 16'd1, 16'h0002);
    rd_reg("rst_bauddiv", BASE + 16'd2, 16'd433);

    // single byte with a 4-clock bit
    wr_reg("bauddiv_ack", BASE + 16'd2, 16'd3);
    bit_clks = 4;
    rd_reg("bauddiv_rb", BASE + 16'd2, 16'd3);
    frame = {1'b1, 8'hA5, 1'b0};
    push_byte(8'hA5, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("a5_tx_bit", 32'(tx), 32'(frame[i/4]));
      if (i == 20) chk("a5_irq_low", 32'(irq), 32'd0);
    end
    drain("a5_drain", 50);
    wait_irq("a5_irq_rise", 20);

    // push lands in the same cycle IDLE pops
    repeat (3) @(negedge clk);
    start_q.delete();
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    rd_reg("pp_status", BASE + 16'd1, 16'h0014);
    drain("pp_drain", 200);
    chk("pp_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() >= 2) chk("pp_frame_gap", 32'(start_q[1] - start_q[0]), 32'd41);
    wait_irq("pp_irq", 20);

    // overflow: ten back-to-back writes, one popped, eight queued, one dropped
    wr_reg("bauddiv100_ack", BASE + 16'd2, 16'd100);
    bit_clks = 101;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i), i < 9);
    rd_reg("ovf_status1", BASE + 16'd1, 16'h008D);
    rd_reg("ovf_status2", BASE + 16'd1, 16'h0085);
    drain("ovf_drain", 9 * 1011 + 200);
    wait_irq("ovf_irq", 200);

    // address decode
    rd_reg("rsvd_read", BASE + 16'd3, 16'h0000);
    wr_reg("rsvd_write_ack", BASE + 16'd3, 16'hFFFF);
    bus(BASE + 16'd4, 1'b1, 16'h0055, 1'b1, a, r);
    chk("out_of_window_wr_ack", 32'(a), 32'd0);
    bus(BASE + 16'd6, 1'b0, 16'h0000, 1'b1, a, r);
    chk("out_of_window_rd_ack", 32'(a), 32'd0);
    chk("out_of_window_rd_dat", 32'(r), 32'd0);
    bus(BASE, 1'b1, 16'h00AA, 1'b0, a, r);
    chk("no_cyc_ack", 32'(a), 32'd0);
    rd_reg("decode_status", BASE + 16'd1, 16'h0002);
    rd_reg("decode_bauddiv", BASE + 16'd2, 16'd100);

    // reset during data bit 3 of 0xF0 (a low bit)
    wr_reg("bauddiv3_ack", BASE + 16'd2, 16'd3);
    bit_clks = 4;
    repeat (2) @(negedge clk);
    push_byte(8'hF0, 1'b1);
    repeat (19) @(posedge clk);
    #2;
    chk("midframe_tx_low", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_irq", 32'(irq), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_reg("post_rst_status", BASE + 16'd1, 16'h0002);
    rd_reg("post_rst_bauddiv", BASE + 16'd2, 16'd433);
    low_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen++;
    end
    chk("no_resume", 32'(low_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
